// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the frame draw scheduler.
//   - sched_state_e : scheduler FSM states
//   - screen geometry (160x120, 3-bit colour) and derived coordinate widths
//   - default drawer count / watchdog limit, index-width helper
package draw_pkg;

    localparam int unsigned ScreenW           = 160;
    localparam int unsigned ScreenH           = 120;
    localparam int unsigned XW                = $clog2(ScreenW);
    localparam int unsigned YW                = $clog2(ScreenH);
    localparam int unsigned ColourW           = 3;
    localparam int unsigned DefaultNumDrawers = 4;
    localparam int unsigned DefaultTimeout    = 255;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StRun,
        StRelease,
        StFinish
    } sched_state_e;

    // Width of an index into n slots; never zero so single-slot builds still work.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: drawer-side handshake/pixel bus plus the VGA plot port.
//   draw_req   : one-hot drawer start (scheduler -> drawers)
//   draw_done  : drawer done flags (drawers -> scheduler)
//   drw_x/y/colour : packed per-drawer pixel outputs, slot i at [W*i +: W]
//   vga_x/y/colour, vga_plot : muxed pixel write to the VGA adapter
// Modports: master = scheduler, slave = drawers + VGA adapter.
interface draw_scheduler_if
    import draw_pkg::*;
#(
    parameter int unsigned NUM_DRAWERS = DefaultNumDrawers
);
    logic [NUM_DRAWERS-1:0]         draw_req;
    logic [NUM_DRAWERS-1:0]         draw_done;
    logic [XW*NUM_DRAWERS-1:0]      drw_x;
    logic [YW*NUM_DRAWERS-1:0]      drw_y;
    logic [ColourW*NUM_DRAWERS-1:0] drw_colour;
    logic [XW-1:0]                  vga_x;
    logic [YW-1:0]                  vga_y;
    logic [ColourW-1:0]             vga_colour;
    logic                           vga_plot;

    modport master (
        output draw_req, vga_x, vga_y, vga_colour, vga_plot,
        input  draw_done, drw_x, drw_y, drw_colour
    );

    modport slave (
        input  draw_req, vga_x, vga_y, vga_colour, vga_plot,
        output draw_done, drw_x, drw_y, drw_colour
    );

endinterface

// File: rtl/draw_watchdog.sv
// draw_watchdog: saturating cycle counter bounding one drawer's run time.
//   clk, reset : clock, async active-low reset
//   clear      : reset count to 0 (takes priority over enable)
//   enable     : count this cycle
//   terminal   : this enabled cycle brings the count up to LIMIT
module draw_watchdog #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CW-1:0] Limit = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};
    assign terminal  = enable && (count_inc >= {1'b0, Limit});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != Limit)) begin
            count_q <= count_inc[CW-1:0];
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: shares the VGA pixel-write port among NUM_DRAWERS sprite drawers.
// Each frame tick runs every enabled drawer in ascending slot order via its
// draw/done handshake and routes the running drawer's pixel to the VGA port.
//   clk, reset     : clock, async active-low reset
//   space_pressed  : synchronous restart, aborts the current pass
//   frame_tick     : starts a pass (queued once if busy)
//   enable_mask    : slots taking part, sampled at pass start
//   bus (master)   : drawer handshake/pixels and VGA plot port
//   frame_busy     : pass in progress (SELECT through FINISH)
//   frame_done     : one-cycle pulse at end of pass
//   overrun        : sticky, tick arrived while busy
//   timeout_err    : sticky, a drawer was aborted by the watchdog
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int unsigned NUM_DRAWERS = DefaultNumDrawers,
    parameter int unsigned TIMEOUT     = DefaultTimeout
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   space_pressed,
    input  logic                   frame_tick,
    input  logic [NUM_DRAWERS-1:0] enable_mask,
    draw_scheduler_if.master       bus,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int unsigned       SlotW    = idx_width(NUM_DRAWERS);
    localparam logic [SlotW-1:0]  LastSlot = SlotW'(NUM_DRAWERS - 1);

    sched_state_e           state_q;
    logic [SlotW-1:0]       slot_q;
    logic [NUM_DRAWERS-1:0] active_mask_q;
    logic [NUM_DRAWERS-1:0] draw_req_q;
    logic                   pending_q;
    logic                   plot_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   overrun_q;
    logic                   timeout_err_q;

    logic                   found;
    logic [SlotW-1:0]       found_slot;
    logic [NUM_DRAWERS-1:0] found_onehot;
    logic                   done_sel;
    logic                   wd_terminal;

    // Lowest active slot at or above the current one; descending loop so the
    // lowest match is written last.
    always_comb begin
        found      = 1'b0;
        found_slot = '0;
        for (int i = NUM_DRAWERS - 1; i >= 0; i--) begin
            if (active_mask_q[i] && (i >= int'(slot_q))) begin
                found      = 1'b1;
                found_slot = SlotW'(i);
            end
        end
    end

    always_comb begin
        found_onehot = '0;
        for (int i = 0; i < NUM_DRAWERS; i++) begin
            found_onehot[i] = (found_slot == SlotW'(i));
        end
    end

    assign done_sel = bus.draw_done[slot_q];

    draw_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q == StSelect),
        .enable   (state_q == StRun),
        .terminal (wd_terminal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            slot_q        <= '0;
            active_mask_q <= '0;
            draw_req_q    <= '0;
            pending_q     <= 1'b0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else if (space_pressed) begin
            // Abort without a frame_done pulse; sticky flags survive.
            state_q       <= StIdle;
            slot_q        <= '0;
            active_mask_q <= '0;
            draw_req_q    <= '0;
            pending_q     <= 1'b0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (frame_tick || pending_q) begin
                        active_mask_q <= enable_mask;
                        slot_q        <= '0;
                        pending_q     <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= StSelect;
                    end
                end
                StSelect: begin
                    if (found) begin
                        slot_q     <= found_slot;
                        draw_req_q <= found_onehot;
                        state_q    <= StRun;
                    end else begin
                        frame_done_q <= 1'b1;
                        state_q      <= StFinish;
                    end
                end
                StRun: begin
                    if (done_sel || wd_terminal) begin
                        draw_req_q <= '0;
                        plot_q     <= 1'b0;
                        state_q    <= StRelease;
                        if (!done_sel) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        // Drawer output lags the request by a cycle.
                        plot_q <= 1'b1;
                    end
                end
                StRelease: begin
                    if (slot_q == LastSlot) begin
                        frame_done_q <= 1'b1;
                        state_q      <= StFinish;
                    end else begin
                        slot_q  <= slot_q + 1'b1;
                        state_q <= StSelect;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // One tick can be queued; a tick on the FINISH cycle is not an overrun.
            if (frame_tick && (state_q != StIdle)) begin
                pending_q <= 1'b1;
                if (state_q != StFinish) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.draw_req = draw_req_q;
    assign bus.vga_plot = plot_q;
    assign frame_busy   = busy_q;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

    always_comb begin
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        if (plot_q) begin
            bus.vga_x      = bus.drw_x[int'(slot_q) * XW +: XW];
            bus.vga_y      = bus.drw_y[int'(slot_q) * YW +: YW];
            bus.vga_colour = bus.drw_colour[int'(slot_q) * ColourW +: ColourW];
        end
    end

endmodule
